// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding the NCO phase increment.
// Optional macro NCO_SWEEP_UPDOWN_EN turns loop mode into a triangle sweep.
module nco_sweep_ctrl #(
    parameter int APR     = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_mode,
    input  logic [APR-1:0]     f_start,
    input  logic [APR-1:0]     f_stop,
    input  logic [APR-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [APR-1:0]     phi_inc_o,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [APR-1:0]     phi_q, phi_d;
    logic [APR-1:0]     start_q, start_d;
    logic [APR-1:0]     stop_q, stop_d;
    logic [APR-1:0]     step_q, step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic               dir_q, dir_d;      // 1 = stepping downwards
    logic               busy_q, busy_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic [APR-1:0]     tgt;

`ifdef NCO_SWEEP_UPDOWN_EN
    logic [APR-1:0]     tgt_q, tgt_d;
    assign tgt = tgt_q;
`else
    assign tgt = stop_q;
`endif

    // One step from cur toward target, computed one bit wider so nothing wraps;
    // any result reaching or passing the target snaps onto it.
    function automatic logic [APR-1:0] next_val(
        input logic [APR-1:0] cur,
        input logic [APR-1:0] target,
        input logic [APR-1:0] step,
        input logic           down
    );
        logic [APR:0] sum;
        logic [APR:0] diff;
        logic [APR-1:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, target};
        if (step == '0) begin
            res = target;
        end else if (!down) begin
            res = (sum >= {1'b0, target}) ? target : sum[APR-1:0];
        end else begin
            res = (diff[APR] || (diff <= {1'b0, step})) ? target : (cur - step);
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        phi_d    = phi_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        loop_d   = loop_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
`ifdef NCO_SWEEP_UPDOWN_EN
        tgt_d    = tgt_q;
`endif
        if (clken) begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        start_d  = f_start;
                        stop_d   = f_stop;
                        step_d   = f_step;
                        dwell_d  = dwell;
                        loop_d   = loop_mode;
                        dir_d    = (f_stop < f_start);
                        phi_d    = f_start;
                        cnt_d    = dwell;
                        busy_d   = 1'b1;
                        strobe_d = 1'b1;
                        state_d  = RUN;
`ifdef NCO_SWEEP_UPDOWN_EN
                        tgt_d    = f_stop;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (phi_q == tgt) begin
                        if (!loop_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
`ifdef NCO_SWEEP_UPDOWN_EN
                            // Turn around at the endpoint and step away at once,
                            // so the endpoint is not dwelt on twice.
                            tgt_d = (tgt_q == stop_q) ? start_q : stop_q;
                            dir_d = ~dir_q;
                            phi_d = next_val(phi_q, tgt_d, step_q, dir_d);
`else
                            phi_d = start_q;
`endif
                            cnt_d    = dwell_q;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        phi_d    = next_val(phi_q, tgt, step_q, dir_q);
                        cnt_d    = dwell_q;
                        strobe_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phi_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            loop_q   <= 1'b0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef NCO_SWEEP_UPDOWN_EN
            tgt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phi_q    <= phi_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            loop_q   <= loop_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
`ifdef NCO_SWEEP_UPDOWN_EN
            tgt_q    <= tgt_d;
`endif
        end
    end

    assign phi_inc_o   = phi_q;
    assign busy        = busy_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;

endmodule
